inst_mem_sync: RTL and testbench
================================

INST_MEM_SYNC -- requirements
Module: inst_mem_sync

Interface
REQ-001 Parameter DATA_W, default 8, instruction word width in bits.
REQ-002 Parameter ADDR_W, default 8, fetch address width in bits.
REQ-003 Parameter DEPTH, default 256, number of stored words; DEPTH SHALL be <= 2**ADDR_W.
REQ-004 Parameter FILL, default all-ones (8'hFF), word returned for unloaded or out-of-range addresses.
REQ-005 Parameter HALT_OP, default 8'b10001000, opcode that sets halt_o when fetched.
REQ-006 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-007 rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 load_start_i  in  1  request to begin a program load.
REQ-009 load_valid_i  in  1  load_data_i carries a word.
REQ-010 load_last_i  in  1  current load word is the final one.
REQ-011 load_data_i  in  DATA_W  program word.
REQ-012 load_ready_o  out  1  block accepts load words (high only in LOAD).
REQ-013 fetch_req_i  in  1  fetch request.
REQ-014 address_i  in  ADDR_W  fetch address.
REQ-015 fetch_ready_o  out  1  fetch accepted this cycle (low only in LOAD).
REQ-016 data_o  out  DATA_W  fetched word.
REQ-017 data_valid_o  out  1  data_o updated by an accepted fetch.
REQ-018 oor_o  out  1  last accepted fetch address was >= loaded word count.
REQ-019 halt_o  out  1  sticky: HALT_OP fetched since last load.
REQ-020 count_o  out  ADDR_W+1  number of words loaded.

Function
REQ-021 FSM states IDLE, LOAD, RUN; IDLE entered on reset.
REQ-022 IDLE/RUN: load_start_i=1 -> LOAD, write pointer and count_o cleared to 0, halt_o cleared, next cycle.
REQ-023 LOAD: load_start_i ignored; each cycle with load_valid_i=1 writes load_data_i to mem[wptr], wptr+1, count_o+1.
REQ-024 LOAD -> RUN after the write with load_last_i=1, or after the write to address DEPTH-1, whichever first; extra words not accepted.
REQ-025 Fetch accepted when fetch_req_i & fetch_ready_o; response exactly 1 cycle later: data_valid_o=1 pulse for one cycle, data_o and oor_o updated.
REQ-026 Response word: mem[address_i] if address_i < count_o, else FILL with oor_o=1.
REQ-027 IDLE: fetches accepted, always return FILL with oor_o=1.
REQ-028 No accepted fetch: data_valid_o=0, data_o and oor_o hold previous values.
REQ-029 halt_o set in the cycle the HALT_OP response is presented; remains 1 until reset or load start.
REQ-030 Back-to-back fetches every cycle SHALL sustain one response per cycle.
REQ-031 Memory contents are not cleared by reset or by load start; count_o alone governs validity.

Reset
REQ-032 rst_ni low asynchronously forces: state IDLE, wptr 0, count_o 0, data_o FILL, data_valid_o 0, oor_o 0, halt_o 0, load_ready_o 0, fetch_ready_o 1.
REQ-033 Reset during LOAD abandons the load; count_o 0 after release.
REQ-034 Deassertion takes effect at the next rising clk_i edge; no request accepted in the release cycle if rst_ni is still low at that edge.

Structure
REQ-035 Shared package inst_mem_pkg holds the state enum (IDLE, LOAD, RUN) and default values of DATA_W, ADDR_W, FILL, HALT_OP.
REQ-036 Storage in one sub-module inst_mem_array: DEPTH x DATA_W, synchronous write, synchronous read, no reset on contents.

Verification
REQ-037 Reset, fetch address 5 in IDLE -> next cycle data_o=0xFF, oor_o=1, data_valid_o=1.
REQ-038 Load 4 words 0xC1,0x90,0xC2,0x88 (last on 4th) -> count_o=4, RUN; fetch 0..3 back-to-back -> 0xC1,0x90,0xC2,0x88 on consecutive cycles, halt_o=1 on the 4th response.
REQ-039 In RUN with count_o=4, fetch address 4 -> data_o=0xFF, oor_o=1; fetch address 1 -> 0x90, oor_o=0.
REQ-040 Load DEPTH words without load_last_i -> RUN after word DEPTH-1, load_ready_o low next cycle, count_o=DEPTH.
REQ-041 rst_ni low after 2 of 4 load words -> IDLE, count_o=0, halt_o=0; fetch address 0 -> 0xFF.
REQ-042 fetch_req_i held high during LOAD -> fetch_ready_o=0, data_valid_o=0 throughout; first fetch after RUN entry answered 1 cycle later.

Source files
------------

// File: rtl/inst_mem_sync_pkg.sv
// Shared definitions for the instruction memory: FSM state encoding and
// default word width, address width, fill word and halt opcode.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int         DEF_DATA_W  = 8;
  localparam int         DEF_ADDR_W  = 8;
  localparam logic [7:0] DEF_FILL    = 8'hFF;
  localparam logic [7:0] DEF_HALT_OP = 8'b10001000;

  // Storage index width; a single-word array still needs one address bit.
  function automatic int mem_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/inst_mem_sync_if.sv
// Load and fetch bus of the instruction memory. The master side is the
// program loader / core, the slave side is inst_mem_sync.
interface inst_mem_sync_if
  import inst_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              load_start_i;
  logic              load_valid_i;
  logic              load_last_i;
  logic [DATA_W-1:0] load_data_i;
  logic              load_ready_o;

  logic              fetch_req_i;
  logic [ADDR_W-1:0] address_i;
  logic              fetch_ready_o;
  logic [DATA_W-1:0] data_o;
  logic              data_valid_o;
  logic              oor_o;
  logic              halt_o;
  logic [ADDR_W:0]   count_o;

  modport master (
    output load_start_i, load_valid_i, load_last_i, load_data_i,
    output fetch_req_i, address_i,
    input  load_ready_o, fetch_ready_o, data_o, data_valid_o,
    input  oor_o, halt_o, count_o
  );

  modport slave (
    input  load_start_i, load_valid_i, load_last_i, load_data_i,
    input  fetch_req_i, address_i,
    output load_ready_o, fetch_ready_o, data_o, data_valid_o,
    output oor_o, halt_o, count_o
  );

endinterface

// File: rtl/inst_mem_sync_array.sv
// Word storage: synchronous write, synchronous read with a read enable so
// the output register holds its value between fetches. Contents never reset.
module inst_mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int MEM_AW = 8
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [MEM_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/inst_mem_sync.sv
// Loadable instruction memory: streams a program in during LOAD, then serves
// single-cycle-latency fetches with out-of-range and sticky halt detection.
module inst_mem_sync
  import inst_mem_pkg::*;
#(
  parameter int               DATA_W  = DEF_DATA_W,
  parameter int               ADDR_W  = DEF_ADDR_W,
  parameter int               DEPTH   = 256,
  parameter logic [DATA_W-1:0] FILL    = DATA_W'(DEF_FILL),
  parameter logic [DATA_W-1:0] HALT_OP = DATA_W'(DEF_HALT_OP)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  inst_mem_sync_if.slave bus
);

  localparam int              MEM_AW   = mem_aw(DEPTH);
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_LOAD = LOAD;
  localparam logic [1:0] S_RUN  = RUN;

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [ADDR_W:0]   wptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              valid_reg;
  logic              oor_reg;
  logic              fill_sel_reg;
  logic              halt_reg;

  logic              in_load;
  logic              fetch_acc;
  logic              start_acc;
  logic              load_acc;
  logic              load_done;
  logic              fetch_oor;
  logic              halt_now;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] data_out;

  assign in_load   = (state_reg == S_LOAD);
  assign fetch_acc = bus.fetch_req_i & ~in_load;
  assign start_acc = bus.load_start_i & ~in_load;
  assign load_acc  = in_load & bus.load_valid_i;
  assign load_done = load_acc & (bus.load_last_i | (wptr_reg == LAST_PTR));

  // Nothing is valid before the first load; otherwise count alone decides.
  assign fetch_oor = (state_reg == S_IDLE) | ({1'b0, bus.address_i} >= count_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_RUN: begin
        if (bus.load_start_i) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_done) begin
          state_next = S_RUN;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= S_IDLE;
      wptr_reg     <= '0;
      count_reg    <= '0;
      valid_reg    <= 1'b0;
      oor_reg      <= 1'b0;
      fill_sel_reg <= 1'b1;
      halt_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      valid_reg <= fetch_acc;
      if (fetch_acc) begin
        oor_reg      <= fetch_oor;
        fill_sel_reg <= fetch_oor;
      end
      if (start_acc) begin
        wptr_reg  <= '0;
        count_reg <= '0;
      end else if (load_acc) begin
        wptr_reg  <= wptr_reg + 1'b1;
        count_reg <= count_reg + 1'b1;
      end
      if (start_acc) begin
        halt_reg <= 1'b0;
      end else if (halt_now) begin
        halt_reg <= 1'b1;
      end
    end
  end

  inst_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .MEM_AW (MEM_AW)
  ) u_array (
    .clk_i (clk_i),
    .we    (load_acc),
    .waddr (wptr_reg[MEM_AW-1:0]),
    .wdata (bus.load_data_i),
    .re    (fetch_acc),
    .raddr (bus.address_i[MEM_AW-1:0]),
    .rdata (ram_q)
  );

  // The read register already holds the word, so the response is a mux, not
  // another pipeline stage; halt is visible in the same cycle as the word.
  assign data_out = fill_sel_reg ? FILL : ram_q;
  assign halt_now = valid_reg & (data_out == HALT_OP);

  assign bus.data_o        = data_out;
  assign bus.data_valid_o  = valid_reg;
  assign bus.oor_o         = oor_reg;
  assign bus.halt_o        = halt_reg | halt_now;
  assign bus.count_o       = count_reg;
  assign bus.load_ready_o  = in_load;
  assign bus.fetch_ready_o = ~in_load;

endmodule

// File: tb/tb_inst_mem_sync.sv
// Randomized scoreboard bench for inst_mem_sync against an array/queue model
// of program load and fetch behaviour.
module tb_inst_mem_sync;

  localparam int         DW    = 8;
  localparam int         AW    = 8;
  localparam int         DEPTH = 256;
  localparam logic [7:0] FILLV = 8'hFF;
  localparam logic [7:0] HALTV = 8'h88;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_mem_sync_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  inst_mem_sync #(
    .DATA_W (DW), .ADDR_W (AW), .DEPTH (DEPTH), .FILL (FILLV), .HALT_OP (HALTV)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       oor;
    logic       halt;
    int         cyc;
  } resp_t;

  resp_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc   = 0;

  // Reference model: program array, loaded word count and mode flags.
  logic [7:0] m_mem [DEPTH];
  int         m_count   = 0;
  bit         m_loading = 0;
  bit         m_running = 0;
  bit         m_halt    = 0;

  bit chk_en = 0;
  bit e_lready, e_fready;
  int e_count;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: status against the model, responses against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_en) begin
        check("load_ready", int'(bus.load_ready_o), int'(e_lready));
        check("fetch_ready", int'(bus.fetch_ready_o), int'(e_fready));
        check("count", int'(bus.count_o), e_count);
      end
      if (bus.data_valid_o) begin
        if (sb.size() == 0) begin
          check("unexpected_response", 1, 0);
        end else begin
          resp_t r;
          r = sb.pop_front();
          $display("resp cyc=%0d data=%02h oor=%0b halt=%0b", cyc, bus.data_o, bus.oor_o, bus.halt_o);
          check("resp_cycle", cyc, r.cyc);
          check("resp_data", int'(bus.data_o), int'(r.data));
          check("resp_oor", int'(bus.oor_o), int'(r.oor));
          check("resp_halt", int'(bus.halt_o), int'(r.halt));
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        void'(sb.pop_front());
        check("missing_response", 0, 1);
      end
    end
  end

  task automatic step(input bit start, input bit valid, input bit last,
                      input logic [7:0] d, input bit freq, input logic [7:0] addr);
    bit    start_acc;
    resp_t r;
    @(posedge clk);
    #1;
    bus.load_start_i = start;
    bus.load_valid_i = valid;
    bus.load_last_i  = last;
    bus.load_data_i  = d;
    bus.fetch_req_i  = freq;
    bus.address_i    = addr;
    e_lready = m_loading;
    e_fready = !m_loading;
    e_count  = m_count;
    chk_en   = 1;

    start_acc = start && !m_loading;
    if (start_acc) m_halt = 0;
    if (freq && !m_loading) begin
      r.oor  = !m_running || (int'(addr) >= m_count);
      r.data = r.oor ? FILLV : m_mem[addr];
      if (r.data == HALTV) m_halt = 1;
      r.halt = m_halt;
      r.cyc  = cyc + 1;
      sb.push_back(r);
    end
    if (start_acc) begin
      m_loading = 1;
      m_running = 0;
      m_count   = 0;
    end else if (m_loading && valid) begin
      m_mem[m_count] = d;
      m_count++;
      if (last || m_count == DEPTH) begin
        m_loading = 0;
        m_running = 1;
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 8'h00, 0, 8'h00);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    chk_en = 0;
    bus.load_start_i = 0; bus.load_valid_i = 0; bus.load_last_i = 0;
    bus.load_data_i  = '0; bus.fetch_req_i = 0; bus.address_i = '0;
    sb.delete();
    m_count = 0; m_loading = 0; m_running = 0; m_halt = 0;
    #2;
    check("rst_data_valid", int'(bus.data_valid_o), 0);
    check("rst_data", int'(bus.data_o), int'(FILLV));
    check("rst_oor", int'(bus.oor_o), 0);
    check("rst_halt", int'(bus.halt_o), 0);
    check("rst_count", int'(bus.count_o), 0);
    check("rst_fetch_ready", int'(bus.fetch_ready_o), 1);
    check("rst_load_ready", int'(bus.load_ready_o), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] prog [4];
    int lim;
    prog[0] = 8'hC1; prog[1] = 8'h90; prog[2] = 8'hC2; prog[3] = 8'h88;

    do_reset();
    // Fetch before any load always misses.
    step(0, 0, 0, 8'h00, 1, 8'd5);
    idle();

    // Four-word program ending in the halt opcode, read back-to-back.
    step(1, 0, 0, 8'h00, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 1, i == 3, prog[i], 0, 8'h00);
    idle();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 1, 8'(i));
    step(0, 0, 0, 8'h00, 1, 8'd4);
    step(0, 0, 0, 8'h00, 1, 8'd1);
    idle();

    // Fetches requested throughout a load are held off.
    step(1, 0, 0, 8'h00, 0, 8'h00);
    for (int i = 0; i < 6; i++)
      step(0, i != 2, i == 5, 8'($urandom), 1, 8'($urandom_range(0, 7)));
    for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 1, 8'($urandom_range(0, 7)));

    // Full-depth load without a last marker; trailing words are refused.
    step(1, 0, 0, 8'h00, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'($urandom), 0, 8'h00);
    step(0, 1, 0, 8'h5A, 1, 8'hFF);
    step(0, 1, 1, 8'hA5, 1, 8'h00);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 8'h00, 1, 8'($urandom));

    // Reset in the middle of a load.
    step(1, 0, 0, 8'h00, 0, 8'h00);
    step(0, 1, 0, 8'h11, 0, 8'h00);
    step(0, 1, 0, 8'h22, 0, 8'h00);
    do_reset();
    step(0, 0, 0, 8'h00, 1, 8'd0);
    idle();

    // Random mix of loads and fetches.
    for (int i = 0; i < 500; i++) begin
      lim = (m_count + 3 > 255) ? 255 : m_count + 3;
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 7) == 0,
           ($urandom_range(0, 5) == 0) ? HALTV : 8'($urandom),
           $urandom_range(0, 9) < 6,
           8'($urandom_range(0, lim)));
    end
    repeat (3) idle();
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
